// File: rtl/phy_tx_pkg.sv
// ---------------------------------------------------------------------------
// phy_tx_pkg
// Shared definitions for the PHY transmit byte-slot scheduler.
//   COM_SYMBOL_DEFAULT : idle / link-training symbol (K28.5 style COM)
//   SLOT_BITS          : width of the in-slot bit counter (8 bits per slot)
//   state_e            : scheduler state, training (INIT) or data (ACTIVE)
// ---------------------------------------------------------------------------
package phy_tx_pkg;

    localparam logic [7:0] COM_SYMBOL_DEFAULT = 8'hBC;
    localparam int         SLOT_BITS          = 3;

    typedef enum logic {
        INIT   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/phy_tx_slot_arbiter_if.sv
// ---------------------------------------------------------------------------
// phy_tx_slot_arbiter_if
// Bundles the two byte-source handshakes and the serializer-facing outputs.
//   data_in0/valid_in0/ready0 : source 0 byte handshake
//   data_in1/valid_in1/ready1 : source 1 byte handshake
//   data_out/valid_out        : byte for the current slot, source data flag
//   grant_src                 : which source supplied data_out
//   bit_idx/load              : serializer bit pointer and byte-load strobe
//   active                    : link training finished
// modport master = byte sources + serializer, modport slave = the scheduler.
// ---------------------------------------------------------------------------
interface phy_tx_slot_arbiter_if;
    import phy_tx_pkg::*;

    logic [7:0]           data_in0;
    logic                 valid_in0;
    logic                 ready0;
    logic [7:0]           data_in1;
    logic                 valid_in1;
    logic                 ready1;
    logic [7:0]           data_out;
    logic                 valid_out;
    logic                 grant_src;
    logic [SLOT_BITS-1:0] bit_idx;
    logic                 load;
    logic                 active;

    modport master (
        output data_in0, valid_in0, data_in1, valid_in1,
        input  ready0, ready1, data_out, valid_out, grant_src,
               bit_idx, load, active
    );

    modport slave (
        input  data_in0, valid_in0, data_in1, valid_in1,
        output ready0, ready1, data_out, valid_out, grant_src,
               bit_idx, load, active
    );

endinterface

// File: rtl/phy_tx_slot_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
//   req[1:0] : request per source
//   last     : source that won the most recent transfer
//   en       : grant window open
//   gnt[1:0] : one-hot (or zero) grant
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);

    // A lone requester always wins; on a tie the source that did not win
    // last time gets the slot.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = en & req[0] & (~req[1] | last);
        gnt[1] = en & req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/phy_tx_slot_arbiter.sv
// ---------------------------------------------------------------------------
// phy_tx_slot_arbiter
// Byte-slot scheduler on the 8x bit clock. Time is cut into 8-cycle slots;
// after reset NUM_COM_INIT COM slots are forced, then two byte sources are
// round-robin arbitrated onto the serializer, idle slots carrying COM.
//   clk_8f : bit-rate clock
//   reset  : synchronous, active-low
//   bus    : source handshakes and serializer outputs (slave modport)
// Parameters: NUM_COM_INIT (>=1) training slots, COM_SYMBOL filler byte.
// ---------------------------------------------------------------------------
module phy_tx_slot_arbiter
    import phy_tx_pkg::*;
#(
    parameter int         NUM_COM_INIT = 4,
    parameter logic [7:0] COM_SYMBOL   = COM_SYMBOL_DEFAULT
) (
    input  logic                  clk_8f,
    input  logic                  reset,
    phy_tx_slot_arbiter_if.slave  bus
);

    localparam int                      COM_CNT_BITS = $clog2(NUM_COM_INIT + 1);
    localparam logic [COM_CNT_BITS-1:0] COM_LAST     = COM_CNT_BITS'(NUM_COM_INIT - 1);

    state_e                  r_state;
    state_e                  w_nextState;
    logic [SLOT_BITS-1:0]    r_cnt;
    logic [COM_CNT_BITS-1:0] r_comCnt;
    logic                    r_last;
    logic [7:0]              r_dataOut;
    logic                    r_validOut;
    logic                    r_grantSrc;
    logic                    w_boundary;
    logic                    w_comDone;
    logic                    w_open;
    logic [1:0]              w_gnt;

    assign w_boundary = (r_cnt == '0);
    assign w_comDone  = (r_comCnt == COM_LAST);

    // State register: training restarts whenever reset is sampled low.
    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: leave training at the boundary closing the last COM slot.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            INIT:    if (w_boundary && w_comDone) w_nextState = ACTIVE;
            ACTIVE:  w_nextState = ACTIVE;
            default: w_nextState = INIT;
        endcase
    end

    // Output decode: the grant window also opens on the final training
    // boundary so the first post-training slot can already carry data.
    always_comb begin
        w_open     = w_boundary && ((r_state == ACTIVE) || w_comDone);
        bus.active = (r_state == ACTIVE);
    end

    rr_arb2 u_arb (
        .req ({bus.valid_in1, bus.valid_in0}),
        .last(r_last),
        .en  (w_open),
        .gnt (w_gnt)
    );

    // Slot counter runs 7 down to 0; training slots are counted at boundaries.
    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            r_cnt    <= '1;
            r_comCnt <= '0;
        end else begin
            r_cnt <= r_cnt - SLOT_BITS'(1);
            if ((r_state == INIT) && w_boundary) begin
                r_comCnt <= r_comCnt + COM_CNT_BITS'(1);
            end
        end
    end

    // Slot payload: a grant is only possible on a boundary, so a grant means
    // a transfer; an ungranted boundary loads COM and keeps grant_src/last.
    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            r_dataOut  <= COM_SYMBOL;
            r_validOut <= 1'b0;
            r_grantSrc <= 1'b0;
            r_last     <= 1'b1;
        end else if (w_gnt != 2'b00) begin
            r_dataOut  <= w_gnt[1] ? bus.data_in1 : bus.data_in0;
            r_validOut <= 1'b1;
            r_grantSrc <= w_gnt[1];
            r_last     <= w_gnt[1];
        end else if (w_boundary) begin
            r_dataOut  <= COM_SYMBOL;
            r_validOut <= 1'b0;
        end
    end

    assign bus.ready0    = w_gnt[0];
    assign bus.ready1    = w_gnt[1];
    assign bus.data_out  = r_dataOut;
    assign bus.valid_out = r_validOut;
    assign bus.grant_src = r_grantSrc;
    assign bus.bit_idx   = r_cnt;
    assign bus.load      = (r_cnt == '1);

endmodule

// File: doc/phy_tx_slot_arbiter.md
# phy_tx_slot_arbiter

Byte-slot scheduler for the PHY transmit path. It runs on the 8× bit clock and divides time into 8-cycle byte slots. After reset it forces a fixed run of COM (8'hBC) link-training symbols. It then round-robin arbitrates two byte sources onto one serializer input, filling idle slots with COM. It also drives the bit index and the byte-load strobe that the parallel-to-serial stage consumes.

## Interface
Parameters:
- NUM_COM_INIT, 4: COM slots forced after reset; legal range ≥1.
- COM_SYMBOL, 8'hBC: idle/training symbol.

Ports:
- clk_8f  in  1  bit-rate clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low.
- data_in0  in  8  source 0 byte.
- valid_in0  in  1  source 0 has a byte; must not depend on ready0.
- ready0  out  1  source 0 byte accepted this cycle when valid_in0=1.
- data_in1  in  8  source 1 byte.
- valid_in1  in  1  source 1 has a byte.
- ready1  out  1  source 1 accept.
- data_out  out  8  byte for the current slot, held stable for all 8 cycles.
- valid_out  out  1  1 = data_out is source data; 0 = COM filler.
- grant_src  out  1  source of the current data_out; meaningful only when valid_out=1.
- bit_idx  out  3  bit of data_out to serialize this cycle, MSB first (7→0).
- load  out  1  first cycle of a slot (bit_idx==7).
- active  out  1  training complete (state ACTIVE).

## Operation
- Slot counter `cnt` (3 b) decrements every cycle and wraps 0→7. `bit_idx` = `cnt`. `load` = (`cnt`==7).
- Slot boundary = the cycle with `cnt`==0. On that cycle's edge, `data_out`/`valid_out`/`grant_src` take the next slot's value.
- FSM states:
  - INIT: `com_cnt` counts completed COM slots, width clog2(NUM_COM_INIT+1). At each boundary `com_cnt`++.
  - INIT→ACTIVE: at the boundary where `com_cnt`==NUM_COM_INIT-1.
  - ACTIVE: no exit except reset.
- Grant window (`open`) = `cnt`==0 && (state==ACTIVE || `com_cnt`==NUM_COM_INIT-1). This makes slot index NUM_COM_INIT the first data-capable slot.
- Arbitration during `open` (combinational on valids):
  - Only one source valid → that source wins.
  - Both valid → the source ≠ `last` wins.
  - Neither valid → no winner.
- `ready`N = `open` && winner==N. At most one ready is high; ready is never high outside `open`.
- Transfer on valid_inN && readyN:
  - next `data_out` = data_inN, `valid_out`=1, `grant_src`=N, `last`=N.
- No transfer at a boundary:
  - next `data_out` = COM_SYMBOL, `valid_out`=0, `grant_src` holds, `last` holds.
- `last` updates only on an actual transfer.
- A source that deasserts valid before its boundary loses the slot with no side effects; its byte is not consumed.
- Reset (reset=0 sampled at an edge):
  - `cnt`=7, `com_cnt`=0, state=INIT, `last`=1 (source 0 wins the first tie).
  - `data_out`=COM_SYMBOL, `valid_out`=0, `grant_src`=0.
  - Reset mid-slot or mid-ACTIVE aborts immediately and restarts training. Held reset keeps these values.

## Timing
- Cycle 0 = first edge with reset=1 sampled after reset.
- Reset and cycle 0 values: `load`=1, `bit_idx`=7, `data_out`=8'hBC, `valid_out`=0, `active`=0, ready0=ready1=0.
- Slot k spans cycles 8k..8k+7. Boundary cycle = 8k+7; ready may rise only there.
- Slots 0..NUM_COM_INIT-1 always carry COM.
- `active`=1 from cycle 8·NUM_COM_INIT.
- Latency: a byte accepted on the boundary cycle 8k+7 appears on `data_out` at cycle 8k+8 and is held through 8k+15.
- Maximum throughput: one byte per 8 cycles, shared by both sources.
- All outputs are registered or decode registered state, except ready0/ready1, which are combinational on valid_in0/valid_in1 and state.

## Structure
- Shared package phy_tx_pkg: COM_SYMBOL default, state enum {INIT, ACTIVE}, SLOT_BITS=3.
- Sub-module rr_arb2: 2-way round-robin with inputs `req[1:0]`, `last`, `en`; outputs `gnt[1:0]`.
- Counters and FSM stay in the top module.

## Test plan
- Reset release, no valids, NUM_COM_INIT=4:
  - `data_out`=8'hBC and `valid_out`=0 for cycles 0–39.
  - `active` rises at cycle 32.
  - `load` high at cycles 0, 8, 16, …
- valid_in0=1 with 8'hA5 from cycle 0:
  - ready0 first high at cycle 31.
  - `data_out`=8'hA5, `valid_out`=1, `grant_src`=0 for cycles 32–39.
  - `bit_idx` sequences 7..0 over the slot.
- Both sources continuously valid (src0 8'h11, src1 8'h22):
  - Slots from 4 onward alternate 11, 22, 11, 22.
  - ready0/ready1 are never high together.
- Source 1 drops valid at cycle 38 while source 0 is idle:
  - Slot 5 is COM with `valid_out`=0.
  - `last` is unchanged.
  - The next valid source wins at cycle 47.
- Reset pulled low at cycle 50 (mid-ACTIVE) for one cycle:
  - Next cycle: `cnt`=7, `data_out`=8'hBC, `active`=0.
  - Four fresh COM slots follow before any ready.
- NUM_COM_INIT=1:
  - ready offered at cycle 7.
  - Data is on `data_out` at cycle 8.
